// File: rtl/payload_writer.sv
// payload_writer: packs an ingress byte stream little-endian into
// eight 64-bit buffer words, pads or truncates, then holds for release.
module payload_writer #(
  parameter int          WORDS    = 8,
  parameter int          ADDR_W   = 3,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [63:0]       mem_data,
  output logic              done,
  output logic [6:0]        byte_count,
  output logic              truncated,
  input  logic              i_release
);

  localparam int NBYTES = WORDS * 8;

  typedef enum logic [1:0] {
    COLLECT,
    PAD,
    DISCARD,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [6:0]        r_idx;
  logic [63:0]       r_word;
  logic              r_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_data;
  logic              r_done;
  logic [6:0]        r_cnt;
  logic              r_trunc;

  logic [2:0]  w_lane;
  logic        w_accept;
  logic        w_full;
  logic        w_pad_end;
  logic [63:0] w_word_ins;
  logic [63:0] w_word_pad;

  assign w_lane    = r_idx[2:0];
  assign w_accept  = in_valid && r_ready;
  assign w_full    = (r_idx == 7'(NBYTES - 1));
  assign w_pad_end = (r_idx[6:3] == 4'(WORDS));

  // Word register with the incoming byte dropped into its lane
  always_comb begin
    w_word_ins = r_word;
    w_word_ins[{w_lane, 3'b000} +: 8] = in_data;
  end

  // Partial word with every unfilled lane forced to the pad value
  always_comb begin
    w_word_pad = '0;
    for (int k = 0; k < 8; k++) begin
      w_word_pad[k*8 +: 8] = (k < int'(w_lane)) ? r_word[k*8 +: 8]
                                                : PAD_BYTE;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_nx;
  end

  // Next-state decode; every in_last in COLLECT drains through PAD
  // so done always lands one cycle after the word-7 write
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (in_last)     w_state_nx = PAD;
          else if (w_full) w_state_nx = DISCARD;
        end
      end
      PAD:     if (w_pad_end) w_state_nx = HOLD;
      DISCARD: if (w_accept && in_last) w_state_nx = HOLD;
      HOLD:    if (i_release) w_state_nx = COLLECT;
      default: w_state_nx = COLLECT;
    endcase
  end

  // Datapath: byte packing, buffer writes, status and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_word  <= '0;
      r_ready <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_ready <= (w_state_nx == COLLECT) || (w_state_nx == DISCARD);
      r_done  <= (w_state_nx == HOLD) && (r_state != HOLD);
      r_wr_en <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_idx <= r_idx + 7'd1;
            r_cnt <= r_cnt + 7'd1;
            if (w_lane == 3'd7) begin
              r_wr_en <= 1'b1;
              r_addr  <= r_idx[ADDR_W+2:3];
              r_data  <= w_word_ins;
              r_word  <= '0;
            end else begin
              r_word  <= w_word_ins;
            end
            if (w_full && !in_last) r_trunc <= 1'b1;
          end
        end
        PAD: begin
          if (!w_pad_end) begin
            r_wr_en <= 1'b1;
            r_addr  <= r_idx[ADDR_W+2:3];
            r_data  <= w_word_pad;
            r_word  <= '0;
            r_idx   <= {r_idx[6:3] + 4'd1, 3'b000};
          end
        end
        HOLD: begin
          if (i_release) begin
            r_idx   <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign mem_wr_en  = r_wr_en;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign done       = r_done;
  assign byte_count = r_cnt;
  assign truncated  = r_trunc;

endmodule

// File: doc/payload_writer.md
Name: payload_writer

Overview:
- Ingress-side counterpart of the payload loader: accepts a packet as a byte stream and packs it little-endian into eight 64-bit words.
- Writes those words into the shared packet buffer at addresses 0..7, then pulses done, which drives the loader's start input.
- Short packets are padded to 64 bytes; bytes beyond 64 are discarded and flagged.
- Holds the buffer until the downstream loader/inference path signals release.

Parameters:
- WORDS, 8, number of 64-bit words per packet buffer (64 bytes)
- ADDR_W, 3, mem_addr width (log2 WORDS)
- PAD_BYTE, 8'h00, fill value for unused byte lanes and words

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  ingress byte valid
- in_data  input  8  ingress byte
- in_last  input  1  marks the final byte of the packet; qualified by in_valid
- in_ready  output  1  writer can accept a byte
- mem_addr  output  ADDR_W  buffer word address
- mem_wr_en  output  1  buffer write strobe, one word per cycle
- mem_data  output  64  write data; byte k of the word is in bits [8k+7:8k]
- done  output  1  one-cycle pulse: buffer complete, starts the loader
- byte_count  output  7  valid payload bytes in the buffer (0..64)
- truncated  output  1  packet exceeded 64 bytes
- release  input  1  downstream has consumed the buffer

Behaviour:
- Byte acceptance: a byte is accepted on a rising edge where in_valid && in_ready.
- Reset (async, any state, including mid-packet):
  - state=COLLECT
  - in_ready=0, mem_wr_en=0, mem_addr=0, mem_data=0, done=0, byte_count=0, truncated=0
  - internal byte index and word register cleared
  - in_ready is registered and rises on the first clk edge after rst deasserts.
- COLLECT (in_ready=1):
  - Each accepted byte is placed at lane byte_index[2:0] of the word register; byte_count increments.
  - When lane 7 is accepted, the next cycle drives mem_wr_en=1, mem_addr=byte_index[5:3], mem_data=completed word.
  - 1-cycle write latency, fully pipelined: a byte may be accepted in the same cycle the previous word is written.
- End of packet in COLLECT:
  - in_last on byte 64 -> final word written as above -> HOLD.
  - in_last on byte n<64 with lane 7 -> that word written; if words remain -> PAD, else -> HOLD.
  - in_last on byte n<64, lane<7 -> PAD.
- Overflow in COLLECT: byte 64 accepted without in_last -> word 7 written -> DISCARD, truncated=1.
- PAD (in_ready=0):
  - First cycle writes the partial word; unfilled lanes are PAD_BYTE.
  - Each following cycle writes one all-PAD_BYTE word, until address 7 is written.
  - Then -> HOLD.
- DISCARD (in_ready=1):
  - Accepted bytes are dropped; byte_count stays at 64.
  - Accepting in_last -> HOLD.
- HOLD (in_ready=0):
  - done=1 in the first HOLD cycle only.
  - byte_count and truncated hold their values.
  - release=1 -> COLLECT on the next edge; byte_count, truncated and byte_index clear; in_ready=1.
- Write count: exactly WORDS writes per packet, addresses strictly 0..7 ascending, never more than one write per cycle. No wrap-around into a second buffer.
- release outside HOLD is ignored. release asserted in the first HOLD cycle is honoured; done still pulses exactly once.
- in_valid while in_ready=0 is ignored; the source must hold its data.
- in_last with in_valid=0 is ignored.

Test Plan:
- 64-byte packet, in_valid continuous, bytes 39,110,109,97,112,39,32,105,... with in_last on byte 64:
  - 8 writes, addr 0..7, mem_data@0=64'h69202770616D6E27.
  - done pulses the cycle after the addr-7 write; byte_count=64, truncated=0, in_ready=0.
- 10-byte packet 0x01..0x0A:
  - word0=64'h0807060504030201, word1=64'h0000000000000A09, words 2..7=0.
  - done after the addr-7 write; byte_count=10.
- 70-byte packet:
  - 8 writes only; truncated=1, byte_count=64.
  - bytes 65-70 accepted and dropped; done the cycle after in_last is accepted.
- 64-byte packet with in_valid toggled every other cycle: identical mem contents to the continuous case, write timing follows the gaps.
- rst asserted after 20 bytes:
  - Immediately in_ready=0, mem_wr_en=0, byte_count=0.
  - Next 64-byte packet fills from addr 0 with correct data.
- Back-to-back packets: in_ready=0 throughout HOLD, in_valid held high; release pulse -> in_ready=1 next cycle, second packet writes from addr 0, done pulses once per packet.
